// File: rtl/isa_io_cycle_arbiter_if.sv
// Requester-side handshake and ISA pad signals of the I/O cycle arbiter.
// slave = arbiter view, master = requesters plus pad wiring in the top level.
interface isa_io_cycle_arbiter_if;
  logic [1:0]  req;
  logic [15:0] req0_addr;
  logic [15:0] req0_wdata;
  logic        req0_write;
  logic [15:0] req1_addr;
  logic [15:0] req1_wdata;
  logic        req1_write;
  logic [1:0]  ack;
  logic [15:0] rdata;
  logic [15:0] isa_addr;
  logic [15:0] isa_dout;
  logic [15:0] isa_din;
  logic        isa_data_oe;
  logic        isa_ior_n;
  logic        isa_iow_n;
  logic        isa_aen;
  logic        busy;

  modport slave (
    input  req, req0_addr, req0_wdata, req0_write,
           req1_addr, req1_wdata, req1_write, isa_din,
    output ack, rdata, isa_addr, isa_dout, isa_data_oe,
           isa_ior_n, isa_iow_n, isa_aen, busy
  );

  modport master (
    output req, req0_addr, req0_wdata, req0_write,
           req1_addr, req1_wdata, req1_write, isa_din,
    input  ack, rdata, isa_addr, isa_dout, isa_data_oe,
           isa_ior_n, isa_iow_n, isa_aen, busy
  );
endinterface

// File: rtl/isa_io_cycle_arbiter.sv
// Round-robin arbiter running full ISA I/O cycles for two requesters.
// Grant-to-ack is SETUP+CMD+HOLD cycles; requests wait (level held) while busy.
module isa_io_cycle_arbiter #(
  parameter int SETUP_CYCLES    = 2,
  parameter int CMD_CYCLES      = 6,
  parameter int HOLD_CYCLES     = 1,
  parameter int RECOVERY_CYCLES = 2
) (
  input  logic                  bus_clock,
  input  logic                  reset_n,
  isa_io_cycle_arbiter_if.slave bus
);

  localparam int CNT_W = 8;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] CMD     = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
  localparam logic [2:0] RECOVER = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;
  logic             last_grant;
  logic             owner;
  logic             dir_write;
  logic [15:0]      addr_q;
  logic [15:0]      dout_q;
  logic [15:0]      rdata_q;
  logic [1:0]       ack_q;
  logic             take;
  logic             pick;
  logic             in_cycle;

  assign cnt_done = (cnt == '0);

  // The edge that ends RECOVER doubles as the IDLE sampling point, giving an
  // S+C+H+R back-to-back period.
  always_comb begin
    pick = bus.req[1];
    if (bus.req == 2'b11) begin
      pick = ~last_grant;
    end
    take = (bus.req != 2'b00) &&
           ((state == IDLE) || ((state == RECOVER) && cnt_done));
  end

  always_ff @(posedge bus_clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      dir_write  <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      rdata_q    <= '0;
      ack_q      <= 2'b00;
    end else begin
      ack_q <= 2'b00;
      case (state)
        IDLE: ;
        SETUP: begin
          if (cnt_done) begin
            state <= CMD;
            cnt   <= CNT_W'(CMD_CYCLES - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CMD: begin
          if (cnt_done) begin
            state <= HOLD;
            cnt   <= CNT_W'(HOLD_CYCLES - 1);
            if (!dir_write) begin
              rdata_q <= bus.isa_din;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_done) begin
            state <= RECOVER;
            cnt   <= CNT_W'(RECOVERY_CYCLES - 1);
            ack_q <= owner ? 2'b10 : 2'b01;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RECOVER: begin
          if (cnt_done) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Winner's transaction is frozen here; later requester input changes are ignored.
      if (take) begin
        state      <= SETUP;
        cnt        <= CNT_W'(SETUP_CYCLES - 1);
        owner      <= pick;
        last_grant <= pick;
        addr_q     <= pick ? bus.req1_addr  : bus.req0_addr;
        dout_q     <= pick ? bus.req1_wdata : bus.req0_wdata;
        dir_write  <= pick ? bus.req1_write : bus.req0_write;
      end
    end
  end

  assign in_cycle = (state == SETUP) || (state == CMD) || (state == HOLD);

  assign bus.isa_aen     = ~in_cycle;
  assign bus.isa_data_oe = in_cycle & dir_write;
  assign bus.isa_iow_n   = ~((state == CMD) & dir_write);
  assign bus.isa_ior_n   = ~((state == CMD) & ~dir_write);
  assign bus.isa_addr    = addr_q;
  assign bus.isa_dout    = dout_q;
  assign bus.rdata       = rdata_q;
  assign bus.ack         = ack_q;
  assign bus.busy        = (state != IDLE);

endmodule
